// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light front end: controller states and path encodings.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic PATH_CAR  = 1'b0;
  localparam logic PATH_WALK = 1'b1;

  // The sequencer is enabled, and the status LED lit, in both RUN and HALT.
  function automatic logic is_active(state_t s);
    return (s == RUN) || (s == HALT);
  endfunction

endpackage

// File: rtl/traffic_if.sv
// Board-facing bundle: raw buttons in, step clock and sequencer controls out.
interface traffic_if;

  logic btn_start;
  logic btn_path;
  logic tick_clk;
  logic start;
  logic path_index;
  logic running;

  modport master (
    output btn_start, btn_path,
    input  tick_clk, start, path_index, running
  );

  modport slave (
    input  btn_start, btn_path,
    output tick_clk, start, path_index, running
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; emits a one-cycle pulse on an accepted press.
module btn_debounce #(
  parameter int DEB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  // The counter only runs while the synchronised input disagrees with the accepted level,
  // so any bounce back to the old level restarts the qualification window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_a <= btn_in;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync_b;
        press <= sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl.sv
// Traffic-light front end: debounces the buttons, divides the board clock to the step rate and
// moves start/path_index only in the cycle after a step-clock rising edge.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1,
  parameter int DEB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  traffic_if.slave bus
);

  localparam int HALF = CLK_HZ / (2 * TICK_HZ);
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [DW-1:0] div_cnt;
  logic          tick_q;
  logic          tick_rise;

  logic          start_level;
  logic          start_press;
  logic          path_level;
  logic          path_press;
  logic          unused_levels;

  state_t        state;
  state_t        next_state;
  logic          active_q;
  logic          path_q;
  logic          path_pend;
  logic          path_window;
  logic          apply_path;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk    (clk),
    .rst    (rst),
    .btn_in (bus.btn_start),
    .level  (start_level),
    .press  (start_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_path (
    .clk    (clk),
    .rst    (rst),
    .btn_in (bus.btn_path),
    .level  (path_level),
    .press  (path_press)
  );

  assign unused_levels = start_level ^ path_level;

  // tick_rise is registered alongside the toggle, so it is high exactly while tick_clk is in
  // its first high cycle and the FSM reacts on the edge after the step-clock rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      tick_q    <= 1'b0;
      tick_rise <= 1'b0;
    end else begin
      tick_rise <= 1'b0;
      if (div_cnt == DW'(HALF - 1)) begin
        div_cnt   <= '0;
        tick_q    <= ~tick_q;
        tick_rise <= ~tick_q;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign path_window = (state == IDLE) || (state == ARM);
  assign apply_path  = path_window && tick_rise && path_pend;

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start_press) next_state = ARM;
      ARM:  if (tick_rise && !path_pend) next_state = RUN;
      RUN:  if (start_press) next_state = HALT;
      HALT: if (tick_rise) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A path press that coincides with a tick_rise stays pending for the following step edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      active_q  <= 1'b0;
      path_q    <= PATH_CAR;
      path_pend <= 1'b0;
    end else begin
      state     <= next_state;
      active_q  <= is_active(next_state);
      path_pend <= path_window ? ((path_pend && !tick_rise) || path_press) : 1'b0;
      if (apply_path) begin
        path_q <= (path_q == PATH_CAR) ? PATH_WALK : PATH_CAR;
      end
    end
  end

  assign bus.tick_clk   = tick_q;
  assign bus.start      = active_q;
  assign bus.running    = active_q;
  assign bus.path_index = path_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl at HALF=5, DEB_CYCLES=4: segment table plus reset/simultaneous-press sequences.
module tb_traffic_ctrl;

  logic clk = 1'b0;
  logic rst;

  traffic_if bus ();

  traffic_ctrl #(
    .CLK_HZ     (100),
    .TICK_HZ    (10),
    .DEB_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  bs;
    logic  bp;
    int    cycles;
    logic  tick;
    logic  start;
    logic  path;
    logic  run;
  } vec_t;

  vec_t vecs [16];

  int checks = 0;
  int passes = 0;

  task automatic check_bit(input string name, input string field, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s.%s: got %b, expected %b", name, field, act, exp);
  endtask

  task automatic check_output(input string name, input logic e_tick, input logic e_start,
                              input logic e_path, input logic e_run);
    check_bit(name, "tick_clk",   bus.tick_clk,   e_tick);
    check_bit(name, "start",      bus.start,      e_start);
    check_bit(name, "path_index", bus.path_index, e_path);
    check_bit(name, "running",    bus.running,    e_run);
  endtask

  // Drive the buttons, let the given number of rising edges pass, then settle 1 ns past the edge.
  task automatic apply_stimulus(input logic bs, input logic bp, input int cycles);
    bus.btn_start = bs;
    bus.btn_path  = bp;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    // Edge n counts rising edges since reset release; tick_clk is high after edges 5-9, 15-19, ...
    vecs[0]  = '{"idle",          1'b0, 1'b0,  3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"bounce_hi1",    1'b1, 1'b0,  3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"bounce_lo",     1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"bounce_hi2",    1'b1, 1'b0,  3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"bounce_settle", 1'b0, 1'b0,  6, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"path_idle",     1'b0, 1'b1,  6, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"path_wait",     1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"path_apply",    1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"start_press",   1'b1, 1'b0,  6, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"arm_wait",      1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{"run_enter",     1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{"path_in_run",   1'b0, 1'b1,  6, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{"run_hold",      1'b0, 1'b0, 14, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{"stop_press",    1'b1, 1'b0,  6, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{"halt_wait",     1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{"halt_exit",     1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b1, 1'b0};

    rst           = 1'b1;
    bus.btn_start = 1'b0;
    bus.btn_path  = 1'b0;
    #12;
    check_output("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].bs, vecs[i].bp, vecs[i].cycles);
      check_output(vecs[i].name, vecs[i].tick, vecs[i].start, vecs[i].path, vecs[i].run);
    end

    // Asynchronous reset between edges while tick_clk and path_index are both high.
    #2;
    rst = 1'b1;
    #1;
    check_output("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    apply_stimulus(1'b0, 1'b0, 4);
    check_output("div_edge4", 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1);
    check_output("div_edge5", 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4);
    check_output("div_edge9", 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1);
    check_output("div_edge10", 1'b0, 1'b0, 1'b0, 1'b0);

    // Both buttons together in IDLE: path flips at the first step edge, start rises at the second.
    apply_stimulus(1'b1, 1'b1, 6);
    check_output("sim_press", 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 9);
    check_output("sim_wait1", 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1);
    check_output("sim_path", 1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 9);
    check_output("sim_wait2", 1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1);
    check_output("sim_run", 1'b1, 1'b1, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
